// File: rtl/mem_dma.sv
// mem_dma: memory-to-memory word copier (RD, CAP, WR per word); define MEM_DMA_CHECKSUM_EN for a checksum port
module mem_dma #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data_in,
  output logic              write_enable,
  output logic              read_enable,
  input  logic [DATA_W-1:0] data_out
`ifdef MEM_DMA_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);
  typedef enum logic [2:0] {IDLE, RD, CAP, WR, FIN} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] src, dst, addr_q;
  logic [ADDR_W:0] cnt;
  logic [DATA_W-1:0] hold, din_q;
  logic accept;
  always_ff @(posedge clk)
    state <= !rst_n ? IDLE : state_nx;
  always_comb begin
    accept = state == IDLE && start;
    state_nx = state == IDLE ? (start ? (length == '0 ? FIN : RD) : IDLE) :
               state == RD   ? CAP :
               state == CAP  ? WR :
               state == WR   ? (cnt != (ADDR_W+1)'(1) ? RD : FIN) : IDLE;
    read_enable = state == RD;
    write_enable = state == WR;
    busy = read_enable || write_enable || state == CAP;
    done = state == FIN;
    address = read_enable ? src : write_enable ? dst : addr_q;
    data_in = write_enable ? hold : din_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      src <= '0;
      dst <= '0;
      cnt <= '0;
      hold <= '0;
      addr_q <= '0;
      din_q <= '0;
    end else begin
      addr_q <= address;
      din_q <= data_in;
      if (accept) begin
        src <= src_addr;
        dst <= dst_addr;
        cnt <= length;
      end
      if (state == CAP) hold <= data_out;
      if (state == WR) begin
        cnt <= cnt - (ADDR_W+1)'(1);
        src <= src + ADDR_W'(1);
        dst <= dst + ADDR_W'(1);
      end
    end
  end
`ifdef MEM_DMA_CHECKSUM_EN
  always_ff @(posedge clk)
    checksum <= !rst_n || accept ? '0 : state == CAP ? checksum + data_out : checksum;
`endif
endmodule

// File: tb/tb_mem_dma.sv
// tb_mem_dma: table-driven, hand-written and random copies of mem_dma checked against a word-copy model
module tb_mem_dma;
  logic clk = 0;
  logic rst_n = 0;
  logic start = 0;
  logic [7:0] src_addr = 0;
  logic [7:0] dst_addr = 0;
  logic [8:0] length = 0;
  logic busy, done, write_enable, read_enable;
  logic [7:0] address;
  logic [15:0] data_in;
  logic [15:0] data_out = 0;
`ifdef MEM_DMA_CHECKSUM_EN
  logic [15:0] checksum;
`endif
  logic [15:0] mem [256];
  logic [15:0] init_mem [256];
  logic [15:0] exp_m [256];
  logic do_load = 0;
  logic [7:0] rd_q [$];
  int wr_n = 0;
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic [7:0] s;
    logic [7:0] d;
    logic [8:0] n;
    int lat;
  } vec_t;
  vec_t vecs [6];

  mem_dma #(.ADDR_W(8), .DATA_W(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .src_addr(src_addr),
    .dst_addr(dst_addr),
    .length(length),
    .busy(busy),
    .done(done),
    .address(address),
    .data_in(data_in),
    .write_enable(write_enable),
    .read_enable(read_enable),
    .data_out(data_out)
`ifdef MEM_DMA_CHECKSUM_EN
    ,
    .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (do_load) mem <= init_mem;
    else begin
      if (write_enable) mem[address] <= data_in;
      if (read_enable) data_out <= mem[address];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    chk("strobe_overlap", {31'd0, read_enable && write_enable}, 0);
    if (read_enable) rd_q.push_back(address);
    if (write_enable) wr_n++;
  end

  task automatic load_mem(input bit fixed);
    for (int i = 0; i < 256; i++) init_mem[i] = 16'($urandom);
    if (fixed) begin
      init_mem[0] = 16'h1234;
      init_mem[1] = 16'hABCD;
      init_mem[2] = 16'h0001;
      init_mem[3] = 16'hFFFF;
    end
    @(negedge clk) do_load = 1;
    @(negedge clk) do_load = 0;
  endtask

  task automatic run_copy(input string name, input logic [7:0] s, input logic [7:0] d,
                          input logic [8:0] n, input int lat, input int poke_at, input int rst_at);
    logic [15:0] sum, v;
    logic [7:0] exp_rd [$];
    int words, reads, got, k, busy_bad, bad, done_seen;
    sum = 0;
    got = 0;
    busy_bad = 0;
    bad = 0;
    done_seen = 0;
    exp_m = mem;
    words = rst_at > 0 ? rst_at / 3 : int'(n);
    reads = rst_at > 0 ? (rst_at + 2) / 3 : int'(n);
    for (int i = 0; i < int'(n); i++) begin
      v = exp_m[8'(s + 8'(i))];
      sum = sum + v;
      if (i < words) exp_m[8'(d + 8'(i))] = v;
      if (i < reads) exp_rd.push_back(8'(s + 8'(i)));
    end
    rd_q.delete();
    wr_n = 0;
    @(negedge clk);
    start = 1;
    src_addr = s;
    dst_addr = d;
    length = n;
    @(posedge clk);
    k = 0;
    while (k < 2000) begin
      @(negedge clk);
      start = 0;
      k++;
      if (k == poke_at) begin
        start = 1;
        src_addr = s + 8'h20;
        dst_addr = d ^ 8'h40;
        length = n + 9'd2;
      end
      if (done) begin
        got = k;
        break;
      end
      if (busy !== 1'b1) busy_bad++;
      if (k == rst_at) begin
        rst_n = 0;
        break;
      end
    end
    if (rst_at > 0) begin
      @(negedge clk);
      chk({name, "_rst_ctl"}, {28'd0, busy, done, read_enable, write_enable}, 0);
      chk({name, "_rst_addr"}, {24'd0, address}, 0);
      chk({name, "_rst_din"}, {16'd0, data_in}, 0);
      @(negedge clk) rst_n = 1;
      repeat (12) @(negedge clk) if (done || busy) done_seen++;
      chk({name, "_no_done"}, done_seen, 0);
    end else begin
      chk({name, "_latency"}, got, lat);
      @(negedge clk);
      chk({name, "_pulse"}, {30'd0, done, busy}, 0);
`ifdef MEM_DMA_CHECKSUM_EN
      chk({name, "_checksum"}, {16'd0, checksum}, {16'd0, sum});
`endif
    end
    chk({name, "_busy"}, busy_bad, 0);
    chk({name, "_nreads"}, rd_q.size(), exp_rd.size());
    for (int i = 0; i < exp_rd.size() && i < rd_q.size(); i++) if (rd_q[i] !== exp_rd[i]) bad++;
    chk({name, "_read_order"}, bad, 0);
    chk({name, "_nwrites"}, wr_n, words);
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== exp_m[i]) bad++;
    chk({name, "_mem"}, bad, 0);
  endtask

  initial begin
    logic [7:0] rs, rdst;
    logic [8:0] rn;
    vecs[0] = '{8'h05, 8'h06, 9'd0, 1};
    vecs[1] = '{8'hFE, 8'h80, 9'd3, 10};
    vecs[2] = '{8'h20, 8'h21, 9'd5, 16};
    vecs[3] = '{8'h30, 8'h10, 9'd1, 4};
    vecs[4] = '{8'h00, 8'h80, 9'd256, 769};
    vecs[5] = '{8'h81, 8'h7F, 9'd6, 19};
    rst_n = 0;
    start = 1;
    length = 9'd2;
    src_addr = 8'h11;
    dst_addr = 8'h22;
    repeat (3) @(negedge clk);
    chk("reset_ctl", {28'd0, busy, done, read_enable, write_enable}, 0);
    rst_n = 1;
    start = 0;
    repeat (3) begin
      @(negedge clk);
      chk("reset_start_ignored", {30'd0, busy, done}, 0);
    end
    chk("reset_addr", {24'd0, address}, 0);
    chk("reset_din", {16'd0, data_in}, 0);
`ifdef MEM_DMA_CHECKSUM_EN
    chk("reset_checksum", {16'd0, checksum}, 0);
`endif
    load_mem(1);
    run_copy("basic4", 8'h00, 8'h10, 9'd4, 13, 0, 0);
    chk("basic4_w0", {16'd0, mem[8'h10]}, 32'h1234);
    chk("basic4_w1", {16'd0, mem[8'h11]}, 32'hABCD);
    chk("basic4_w2", {16'd0, mem[8'h12]}, 32'h0001);
    chk("basic4_w3", {16'd0, mem[8'h13]}, 32'hFFFF);
`ifdef MEM_DMA_CHECKSUM_EN
    chk("basic4_sum", {16'd0, checksum}, 32'hBE01);
`endif
    for (int i = 0; i < 6; i++)
      run_copy($sformatf("vec%0d", i), vecs[i].s, vecs[i].d, vecs[i].n, vecs[i].lat, 0, 0);
    load_mem(0);
    run_copy("reset_mid", 8'h20, 8'h30, 9'd4, 0, 0, 5);
    run_copy("start_busy", 8'h40, 8'h50, 9'd3, 10, 4, 0);
    for (int i = 0; i < 20; i++) begin
      rs = 8'($urandom);
      rdst = 8'($urandom);
      rn = 9'($urandom_range(0, 10));
      run_copy($sformatf("rand%0d", i), rs, rdst, rn, rn == 0 ? 1 : 3 * int'(rn) + 1, 0, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
